// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_counter_bank_pkg;

    // Bank control states; encodings are visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned NUM_EVT_DEF = 6;

    // Event channel indices into evt.
    localparam int unsigned EVT_INST  = 0;
    localparam int unsigned EVT_IREQ  = 1;
    localparam int unsigned EVT_IHIT  = 2;
    localparam int unsigned EVT_DREQ  = 3;
    localparam int unsigned EVT_DHIT  = 4;
    localparam int unsigned EVT_STALL = 5;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with wrap or saturate behaviour and a sticky overflow flag.
module perf_counter
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic at_max_c;

    assign at_max_c = (value == ALL_ONES);

    // Count update: clr beats increment; hold freezes the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc && !hold) begin
            if (at_max_c) begin
                ovf <= 1'b1;
                if (SAT_MODE == 0) begin
                    value <= '0;
                end
            end else begin
                value <= value + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of per-event counters plus a cycle counter, gated by a run/freeze FSM,
// with a one-cycle-latency registered read port.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned NUM_EVT  = NUM_EVT_DEF,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [NUM_EVT-1:0]                 evt,
    input  logic                               hlt,
    input  logic                               clr,
    input  logic                               rd_req,
    input  logic [$clog2(NUM_EVT+1)-1:0]       rd_sel,
    output logic [CNT_W-1:0]                   rd_data,
    output logic                               rd_valid,
    output logic                               rd_err,
    output logic [NUM_EVT:0]                   ovf,
    output logic [STATE_W-1:0]                 state_o
);

    localparam int unsigned NUM_CNT = NUM_EVT + 1;
    localparam int unsigned SEL_W   = $clog2(NUM_EVT + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] inc_c;
    logic               hold_c;
    logic [CNT_W-1:0]   rd_mux_c;
    logic               rd_oob_c;

    // Top counter is the cycle counter and sees an increment every cycle.
    assign inc_c   = {1'b1, evt};
    assign hold_c  = (state != ST_RUN);
    assign state_o = state;

    // One counter per event channel plus the cycle counter.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_c[i]),
            .clr   (clr),
            .hold  (hold_c),
            .value (cnt[i]),
            .ovf   (ovf[i])
        );
    end

    // Control FSM; the hlt cycle itself still counts because state is RUN then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (hlt)      state <= ST_FROZEN;
                    else if (!en) state <= ST_IDLE;
                end
                ST_FROZEN: begin
                    if (clr) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read select; out-of-range indices return zero.
    always_comb begin
        rd_mux_c = '0;
        rd_oob_c = (rd_sel > SEL_W'(NUM_EVT));
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux_c = cnt[i];
        end
    end

    // Read response register; samples counters before this cycle's update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_err   <= rd_req && rd_oob_c;
            rd_data  <= rd_req ? rd_mux_c : '0;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: three bank instances (32-bit wrap, 8-bit wrap, 8-bit
// saturate) share one stimulus stream; reads push expected responses and a
// monitor pops them whenever a bank presents rd_valid.
module tb_perf_counter_bank;
    import perf_counter_bank_pkg::*;

    localparam int unsigned NE    = 6;
    localparam int unsigned SEL_W = 3;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, en, hlt, clr, rd_req;
    logic [NE-1:0] evt;
    logic [SEL_W-1:0] rd_sel;

    logic [31:0] d0_data;
    logic [7:0]  d1_data, d2_data;
    logic        d0_valid, d1_valid, d2_valid;
    logic        d0_err, d1_err, d2_err;
    logic [NE:0] d0_ovf, d1_ovf, d2_ovf;
    logic [1:0]  d0_state, d1_state, d2_state;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;
    int   rd_tag   = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(32), .SAT_MODE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(d0_data), .rd_valid(d0_valid),
        .rd_err(d0_err), .ovf(d0_ovf), .state_o(d0_state));

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(8), .SAT_MODE(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(d1_data), .rd_valid(d1_valid),
        .rd_err(d1_err), .ovf(d1_ovf), .state_o(d1_state));

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(8), .SAT_MODE(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(d2_data), .rd_valid(d2_valid),
        .rd_err(d2_err), .ovf(d2_ovf), .state_o(d2_state));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Issue one read for one cycle and queue the expected response per bank.
    task automatic rd(input int sel, input logic [63:0] e0, input logic [63:0] e1,
                      input logic [63:0] e2, input logic err);
        rd_req = 1'b1;
        rd_sel = 3'(sel);
        q0.push_back('{data: e0, err: err, tag: rd_tag});
        q1.push_back('{data: e1, err: err, tag: rd_tag});
        q2.push_back('{data: e2, err: err, tag: rd_tag});
        rd_tag++;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic chk_all_state(input string name, input logic [1:0] exp);
        chk({name, "_d0"}, 64'(d0_state), 64'(exp));
        chk({name, "_d1"}, 64'(d1_state), 64'(exp));
        chk({name, "_d2"}, 64'(d2_state), 64'(exp));
    endtask

    task automatic chk_ovf(input string name, input logic [NE:0] e0,
                           input logic [NE:0] e1, input logic [NE:0] e2);
        chk({name, "_d0"}, 64'(d0_ovf), 64'(e0));
        chk({name, "_d1"}, 64'(d1_ovf), 64'(e1));
        chk({name, "_d2"}, 64'(d2_ovf), 64'(e2));
    endtask

    task automatic mon_one(input int d, input logic v, input logic e, input logic [63:0] dat);
        exp_t x;
        int   n;
        if (!v) return;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rd_valid dut%0d got data=%0d expected no read", d, dat);
            return;
        end
        case (d)
            0:       x = q0.pop_front();
            1:       x = q1.pop_front();
            default: x = q2.pop_front();
        endcase
        chk($sformatf("rd%0d_data_dut%0d", x.tag, d), dat, x.data);
        chk($sformatf("rd%0d_err_dut%0d", x.tag, d), 64'(e), 64'(x.err));
    endtask

    // Monitor: compare every presented read response against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            mon_one(0, d0_valid, d0_err, 64'(d0_data));
            mon_one(1, d1_valid, d1_err, 64'(d1_data));
            mon_one(2, d2_valid, d2_err, 64'(d2_data));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        hlt    = 1'b0;
        clr    = 1'b0;
        rd_req = 1'b0;
        rd_sel = '0;
        evt    = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk_all_state("reset_state", 2'd0);
        chk_ovf("reset_ovf", '0, '0, '0);
        chk("reset_rd_valid", 64'(d0_valid), 64'd0);
        chk("reset_rd_data", 64'(d0_data), 64'd0);
        rd(0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Run, count inst retire for 10 cycles including the hlt cycle, then freeze
        en = 1'b1;
        tick();
        chk_all_state("run_state", 2'd1);
        evt[EVT_INST] = 1'b1;
        repeat (9) tick();
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        chk_all_state("frozen_state", 2'd2);
        repeat (3) tick();
        evt = '0;
        chk_all_state("frozen_hold", 2'd2);
        rd(EVT_INST, 64'd10, 64'd10, 64'd10, 1'b0);
        rd(NE, 64'd10, 64'd10, 64'd10, 1'b0);
        chk_ovf("frozen_ovf", '0, '0, '0);

        // clr leaves FROZEN for IDLE and zeroes counters
        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_all_state("clr_frozen_state", 2'd0);
        rd(EVT_INST, 64'd0, 64'd0, 64'd0, 1'b0);

        // 260 icache req pulses: 32-bit plain, 8-bit wraps, 8-bit saturates
        en = 1'b1;
        tick();
        evt[EVT_IREQ] = 1'b1;
        repeat (260) tick();
        evt = '0;
        en  = 1'b0;
        tick();
        chk_all_state("en_drop_state", 2'd0);
        chk_ovf("wrap_ovf", 7'b0000000, 7'b1000010, 7'b1000010);
        rd(EVT_IREQ, 64'd260, 64'd4, 64'd255, 1'b0);
        rd(NE, 64'd261, 64'd5, 64'd255, 1'b0);

        // clr with simultaneous increment; read in that cycle sees the old value
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b1;
        tick();
        evt[EVT_IHIT] = 1'b1;
        repeat (5) tick();
        clr = 1'b1;
        rd(EVT_IHIT, 64'd5, 64'd5, 64'd5, 1'b0);
        clr = 1'b0;
        evt = '0;
        chk_all_state("clr_run_state", 2'd1);
        en = 1'b0;
        rd(EVT_IHIT, 64'd0, 64'd0, 64'd0, 1'b0);
        chk_ovf("clr_ovf", '0, '0, '0);

        // Distinct counts per channel then seven back-to-back reads
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b1;
        tick();
        evt = 6'b111111; tick();
        evt = 6'b011111; tick();
        evt = 6'b001111; tick();
        evt = 6'b000111; tick();
        evt = 6'b000011; tick();
        evt = 6'b000001; tick();
        evt = '0;
        en  = 1'b0;
        tick();
        rd(0, 64'd6, 64'd6, 64'd6, 1'b0);
        rd(1, 64'd5, 64'd5, 64'd5, 1'b0);
        rd(2, 64'd4, 64'd4, 64'd4, 1'b0);
        rd(3, 64'd3, 64'd3, 64'd3, 1'b0);
        rd(4, 64'd2, 64'd2, 64'd2, 1'b0);
        rd(5, 64'd1, 64'd1, 64'd1, 1'b0);
        rd(6, 64'd7, 64'd7, 64'd7, 1'b0);

        // Out-of-range select
        rd(7, 64'd0, 64'd0, 64'd0, 1'b1);

        // Reset in RUN with a read pending; the read is dropped
        en = 1'b1;
        tick();
        evt[EVT_INST] = 1'b1;
        tick();
        tick();
        rst_n  = 1'b0;
        en     = 1'b0;
        evt    = '0;
        rd_req = 1'b1;
        rd_sel = 3'd0;
        tick();
        rst_n  = 1'b1;
        rd_req = 1'b0;
        chk_all_state("midrst_state", 2'd0);
        chk("midrst_no_valid", 64'(d0_valid), 64'd0);
        chk_ovf("midrst_ovf", '0, '0, '0);
        rd(EVT_INST, 64'd0, 64'd0, 64'd0, 1'b0);
        rd(NE, 64'd0, 64'd0, 64'd0, 1'b0);

        // Drain and confirm every queued read was answered
        repeat (3) tick();
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_q2", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_EVT, default 6, number of event channels (0 inst retire, 1 icache req, 2 icache hit, 3 dcache req, 4 dcache hit, 5 stall).
REQ-002 Parameter CNT_W, default 32, width of every counter, legal range 8..64.
REQ-003 Parameter SAT_MODE, default 0, 0 = counters wrap, 1 = counters saturate at all-ones.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  level; IDLE->RUN request.
REQ-007 evt  input  NUM_EVT  per-channel event strobe, one count per high cycle.
REQ-008 hlt  input  1  CPU halt indication; freezes the bank.
REQ-009 clr  input  1  single-cycle pulse; zeroes all counters and overflow flags.
REQ-010 rd_req  input  1  single-cycle read request.
REQ-011 rd_sel  input  $clog2(NUM_EVT+1)  read index; NUM_EVT selects cycle counter.
REQ-012 rd_data  output  CNT_W  read result.
REQ-013 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-014 rd_err  output  1  one-cycle pulse with rd_valid when rd_sel > NUM_EVT.
REQ-015 ovf  output  NUM_EVT+1  sticky per-counter overflow flags, bit NUM_EVT = cycle counter.
REQ-016 state_o  output  2  current state encoding (IDLE=0, RUN=1, FROZEN=2).

Function
REQ-017 States IDLE, RUN, FROZEN; IDLE->RUN when en=1; RUN->FROZEN when hlt=1; FROZEN->IDLE only on clr; RUN->IDLE when en=0.
REQ-018 In RUN, counter i increments by 1 each cycle evt[i]=1; cycle counter increments every RUN cycle.
REQ-019 The cycle in which hlt rises in RUN is counted (events and cycle), with no counting from the next cycle on.
REQ-020 In IDLE and FROZEN, evt is ignored and all counters hold.
REQ-021 SAT_MODE=0: all-ones +1 -> 0 and corresponding ovf bit set; SAT_MODE=1: counter holds all-ones and ovf bit set.
REQ-022 ovf bits are sticky until clr or reset.
REQ-023 clr zeroes all counters and ovf in the next cycle and wins over a simultaneous increment; clr in RUN keeps state RUN.
REQ-024 Read latency is exactly 1 cycle: rd_req at edge N -> rd_valid, rd_data at edge N+1.
REQ-025 Read returns counter value sampled before any same-cycle increment or clr.
REQ-026 rd_sel > NUM_EVT: rd_data=0, rd_err=1, rd_valid=1.
REQ-027 Back-to-back rd_req every cycle is supported with no bubbles.
REQ-028 Reads are honoured in every state.

Reset
REQ-029 rst_n=0 at a clock edge: state IDLE, all counters 0, ovf 0, rd_data 0, rd_valid 0, rd_err 0.
REQ-030 Reset mid-operation (RUN or FROZEN, pending read) discards the pending read; no rd_valid on the cycle after reset.
REQ-031 Reset has priority over clr, en, hlt and rd_req.

Structure
REQ-032 Shared package holds the state enum, state encodings and event-index constants (EVT_INST, EVT_IHIT, etc.).
REQ-033 One sub-module perf_counter (CNT_W, SAT_MODE; inc, clr, hold inputs; value, ovf outputs) instantiated NUM_EVT+1 times.
REQ-034 Read mux and state machine live in perf_counter_bank.

Verification
REQ-035 Reset, en=1, evt[0]=1 for 10 cycles, hlt pulse -> state FROZEN, read sel 0 returns 10 (hlt-cycle included if evt high), further evt ignored.
REQ-036 CNT_W=8, SAT_MODE=0, 260 evt[1] pulses -> read returns 4, ovf[1]=1; SAT_MODE=1 -> read returns 255, ovf[1]=1.
REQ-037 clr asserted same cycle as evt[2]=1 with counter 5 -> next-cycle read returns 0, ovf all 0.
REQ-038 rd_req on 7 consecutive cycles, sel 0..6 (NUM_EVT=6) -> 7 consecutive rd_valid, sel 6 = cycle count, no rd_err.
REQ-039 rd_sel=7 -> rd_valid=1, rd_err=1, rd_data=0.
REQ-040 rst_n low for one cycle in RUN with rd_req pending -> state IDLE, all counters 0, no rd_valid next cycle.
